// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with ALU/LSU write-back ports and a busy scoreboard.
// Latency: reads are combinational (optionally forwarding same-cycle writes); writes, reserve, release and flush land at the next rising edge.
// Backpressure: none; every write, reservation and flush is accepted in the cycle it is presented.
module regfile_mp #(
  parameter int DW     = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush
);

  // One write-back request after qualification (address 0 and reset already filtered out).
  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t             wr0;
  wr_t             wr1;
  logic            wr0_keep;
  logic            rsv_act;
  logic [DW-1:0]   mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Qualify the write and reserve requests; x0 is hard-wired and nothing is forwarded while in reset.
  always_comb begin
    wr0.en   = we0 && (waddr0 != '0) && rst_n;
    wr0.addr = waddr0;
    wr0.dat  = wdata0;
    wr1.en   = we1 && (waddr1 != '0) && rst_n;
    wr1.addr = waddr1;
    wr1.dat  = wdata1;
    // The LSU port owns the entry when both ports hit the same register.
    wr0_keep = wr0.en && !(wr1.en && (wr1.addr == wr0.addr));
    rsv_act  = rsv_en && (rsv_addr != '0);
  end

  // Register array: cleared by reset, written by up to two write-back ports per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (wr0_keep) begin
        mem[wr0.addr] <= wr0.dat;
      end
      if (wr1.en) begin
        mem[wr1.addr] <= wr1.dat;
      end
    end
  end

  // Scoreboard next state: write-back releases, a reservation re-arms (new producer wins), flush clears everything.
  always_comb begin
    busy_nxt = busy;
    if (wr0.en) begin
      busy_nxt[wr0.addr] = 1'b0;
    end
    if (wr1.en) begin
      busy_nxt[wr1.addr] = 1'b0;
    end
    if (rsv_act) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    assign ra = raddr[i*AW +: AW];

    // Array read, optionally forwarding this cycle's write-back with the LSU port taking priority.
    always_comb begin
      rd = mem[ra];
      if (BYPASS) begin
        if (wr1.en && (wr1.addr == ra)) begin
          rd = wr1.dat;
        end else if (wr0.en && (wr0.addr == ra)) begin
          rd = wr0.dat;
        end
      end
      if (ra == '0) begin
        rd = '0;
      end
    end

    assign rdata[i*DW +: DW] = rd;
    // Busy reflects registered state only; reserve/release are not forwarded.
    assign rbusy[i] = busy[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share all inputs,
// directed steps followed by random traffic, compared against an array/scoreboard model.
module tb_regfile_mp;
  localparam int DW   = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata_b, rdata_n;
  logic [NRD-1:0]    rbusy_b, rbusy_n;
  logic              we0, we1, rsv_en, flush;
  logic [AW-1:0]     waddr0, waddr1, rsv_addr;
  logic [DW-1:0]     wdata0, wdata1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [NREG];
  bit            m_busy [NREG];

  regfile_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  regfile_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected read value: x0 and reset read zero; forwarding (LSU first) only when bypassing.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!rst_n || a == '0) return '0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return m_reg[a];
  endfunction

  function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
    if (!rst_n || a == '0) return '0;
    return {{(DW-1){1'b0}}, m_busy[a]};
  endfunction

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  // Called in the low phase with inputs set: compare all outputs, then advance one edge and update the model.
  task automatic step();
    logic [AW-1:0] a;
    #1;
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        m_reg[k] = '0;
        m_busy[k] = 1'b0;
      end
    end
    for (int i = 0; i < NRD; i++) begin
      a = raddr[i*AW +: AW];
      chk($sformatf("rdata_byp[%0d] a=%0d", i, a), rdata_b[i*DW +: DW], exp_rd(a, 1'b1));
      chk($sformatf("rdata_nob[%0d] a=%0d", i, a), rdata_n[i*DW +: DW], exp_rd(a, 1'b0));
      chk($sformatf("rbusy_byp[%0d] a=%0d", i, a), {{(DW-1){1'b0}}, rbusy_b[i]}, exp_busy(a));
      chk($sformatf("rbusy_nob[%0d] a=%0d", i, a), {{(DW-1){1'b0}}, rbusy_n[i]}, exp_busy(a));
    end
    @(posedge clk);
    if (rst_n) begin
      if (we0 && waddr0 != '0) begin m_reg[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != '0) begin m_reg[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1'b1;
      if (flush) for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [NRD*AW-1:0] ra2(input logic [AW-1:0] p1, input logic [AW-1:0] p0);
    return {p1, p0};
  endfunction

  initial begin
    idle();
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; rsv_addr = '0;
    rst_n = 1'b0;
    raddr = ra2(5'd3, 5'd0);
    @(negedge clk);

    // Reset held, then released.
    step(); step();
    #1 chk("rst_rdata_p1", rdata_b[2*DW-1:DW], 64'h0);
    rst_n = 1'b1;
    step();

    // Basic write then read.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hDEAD_BEEF_0000_0001;
    raddr = ra2(5'd0, 5'd5);
    step(); idle();
    #1 chk("wr_x5_nob", rdata_n[DW-1:0], 64'hDEAD_BEEF_0000_0001);
    step();

    // Write to x0 is dropped.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = '1;
    step(); idle();
    #1 chk("x0_zero", rdata_b[2*DW-1:DW], 64'h0);
    step();

    // Dual write same address: LSU wins.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 64'h22;
    raddr = ra2(5'd7, 5'd7);
    step(); idle();
    #1 chk("dual_same_x7", rdata_n[DW-1:0], 64'h22);
    step();

    // Dual write different addresses.
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 64'h88;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'h99;
    raddr = ra2(5'd9, 5'd8);
    step(); idle();
    #1 chk("dual_x8", rdata_n[DW-1:0], 64'h88);
    chk("dual_x9", rdata_n[2*DW-1:DW], 64'h99);
    step();

    // Bypass versus no bypass.
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 64'hABCD;
    raddr = ra2(5'd10, 5'd10);
    #1 chk("bypass_same_cycle", rdata_b[DW-1:0], 64'hABCD);
    chk("nobypass_old", rdata_n[DW-1:0], 64'h0);
    step(); idle();
    #1 chk("nobypass_next", rdata_n[DW-1:0], 64'hABCD);
    step();

    // Scoreboard reserve / release / set-wins.
    rsv_en = 1'b1; rsv_addr = 5'd12;
    raddr = ra2(5'd12, 5'd12);
    #1 chk("rsv_no_bypass", {63'b0, rbusy_b[0]}, 64'h0);
    step(); idle();
    #1 chk("rsv_busy", {63'b0, rbusy_b[0]}, 64'h1);
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 64'h1212;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step(); idle();
    #1 chk("set_wins", {63'b0, rbusy_n[1]}, 64'h1);
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 64'h3434;
    step(); idle();
    #1 chk("release", {63'b0, rbusy_b[1]}, 64'h0);
    step();

    // Flush beats a same-cycle reservation.
    rsv_en = 1'b1; rsv_addr = 5'd4; step();
    rsv_addr = 5'd5; step();
    rsv_addr = 5'd6; raddr = ra2(5'd5, 5'd4); step();
    idle();
    #1 chk("busy_x4", {63'b0, rbusy_b[0]}, 64'h1);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd7;
    step(); idle();
    raddr = ra2(5'd7, 5'd6);
    #1 chk("flush_x7", {63'b0, rbusy_b[1]}, 64'h0);
    chk("flush_x6", {63'b0, rbusy_b[0]}, 64'h0);
    step();

    // Mid-cycle asynchronous reset after writes.
    raddr = ra2(5'd8, 5'd5);
    rst_n = 1'b0;
    #1 chk("async_rst_x5", rdata_b[DW-1:0], 64'h0);
    chk("async_rst_x8", rdata_n[2*DW-1:DW], 64'h0);
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic biased towards a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 60) != 0);
      raddr    = ra2(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      we0      = 1'($urandom);
      waddr0   = 5'($urandom_range(0, 15));
      wdata0   = {$urandom, $urandom};
      we1      = 1'($urandom);
      waddr1   = 5'($urandom_range(0, 15));
      wdata1   = {$urandom, $urandom};
      rsv_en   = 1'($urandom);
      rsv_addr = 5'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor of the single-write, two-read core register file.
- Adds:
  - configurable data width, register count and read-port count;
  - two write-back ports (ALU and LSU paths) with a fixed priority;
  - optional write-to-read bypass;
  - a per-register busy scoreboard for issue-stage hazard detection.
- Sits between decode/issue (reads, busy query, reservation) and write-back (writes, busy release).

Parameters:
- DW, 64, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, 5, address width; equals log2(NREG).
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a read observes a same-cycle write; 0 = a read returns the pre-edge array contents.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*DW  read data; port i occupies bits [i*DW +: DW].
- rbusy  out  NRD  busy bit of the register addressed by read port i.
- we0  in  1  write-back port 0 enable (ALU).
- waddr0  in  AW  write-back port 0 address.
- wdata0  in  DW  write-back port 0 data.
- we1  in  1  write-back port 1 enable (LSU).
- waddr1  in  AW  write-back port 1 address.
- wdata1  in  DW  write-back port 1 data.
- rsv_en  in  1  reserve destination register: set its busy bit.
- rsv_addr  in  AW  register to reserve.
- flush  in  1  synchronous clear of all busy bits; array contents unaffected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NREG entries cleared to 0;
  - all busy bits cleared;
  - every rdata reads 0 and every rbusy reads 0 while reset is held.
  - Release is sampled on clk; the first write can take effect at the first rising edge with rst_n high.
- Register 0:
  - reads always 0, rbusy always 0;
  - writes and reservations to address 0 are dropped.
- Writes:
  - performed on the rising edge, one cycle of latency to the array.
  - Both ports enabled to the same address: port 1 (LSU) wins; port 0 data is discarded.
  - Different addresses: both entries are written in the same cycle.
- Reads: combinational from raddr; zero-cycle latency.
  - BYPASS=1: if raddr[i] matches an enabled write address (non-zero), rdata[i] returns that wdata, with port 1 taking priority over port 0. Otherwise rdata[i] returns the array entry.
  - BYPASS=0: rdata[i] always returns the array entry; new data is visible from the cycle after the write.
- Scoreboard (NREG busy flops; flop 0 tied to 0):
  - rsv_en sets busy[rsv_addr] at the edge.
  - A write on either port clears busy[waddr] at the edge.
  - Set and clear of the same register in the same cycle: set wins (a new producer was issued).
  - flush clears all busy bits at the edge and has priority over rsv_en in the same cycle.
  - rbusy[i] reflects the registered busy state only; there is no same-cycle bypass of reserve or release.
- No internal state machine beyond the array and scoreboard. Every output is a function of registered state, except the bypass paths from the write ports to rdata.
- Mid-operation reset: pending writes and reservations are lost, and the array and busy state return to 0 immediately.

Test Plan:
- Reset then read: hold rst_n=0 with raddr={5'd3,5'd0} -> rdata all zero, rbusy=0; release reset -> still zero.
- Basic write/read: we0=1, waddr0=5, wdata0=64'hDEAD_BEEF_0000_0001; next cycle raddr port0=5 -> rdata=64'hDEAD_BEEF_0000_0001. Write 64'hFFFF... to x0 -> x0 still reads 0.
- Dual write, same address: we0 and we1 both targeting address 7 with data 64'h11 and 64'h22 -> x7 reads 64'h22 the next cycle. Different addresses 8 and 9 -> both written.
- Bypass: BYPASS=1, write 64'hABCD to x10 while raddr=10 -> same-cycle rdata=64'hABCD. BYPASS=0, same stimulus -> old value that cycle, 64'hABCD the next cycle.
- Scoreboard: rsv_en with addr 12 -> rbusy=1 from the next cycle. Write-back to x12 together with rsv_en to 12 in the same cycle -> busy stays 1. A later write to x12 alone -> busy 0.
- Flush and async reset: reserve x4, x5, x6, then flush together with rsv_en to 7 -> all busy bits 0, including x7. Assert rst_n low mid-cycle after writes -> outputs go to 0 before the next edge.
